// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: the operating modes
// and the legal width range.
package usr_pkg;

    // Operating modes selected by the 2-bit mode input
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    // True when a mode moves data by one bit in either direction
    function automatic logic is_shift(input mode_t m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/usr_frame_cnt.sv
// Frame counter for the universal shift register. Counts shifts since the
// last load/clear, wraps after WIDTH shifts and emits a registered
// one-cycle frame_done pulse in the cycle that follows the wrapping shift.
module usr_frame_cnt #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Count shifts, clear on load, pulse frame_done on the wrapping shift
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (clr) begin
                shift_cnt <= '0;
            end else if (inc) begin
                if (shift_cnt == CNT_LAST) begin
                    shift_cnt  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    shift_cnt <= shift_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/usr_shift_reg.sv
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load, with serial in/out at both ends and a frame counter.
// Optional rotate support is compiled in when USR_ROTATE_EN is defined;
// otherwise the rot input is accepted but has no effect.
module usr_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             rot,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    // Reject unsupported widths at elaboration time
    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("usr_shift_reg: WIDTH must be in the range 2 to 64");
        end
    endgenerate

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic             fill_r;
    logic             fill_l;
    mode_t            mode_e;
    logic             inc;
    logic             clr;

    assign mode_e = mode_t'(mode);

`ifdef USR_ROTATE_EN
    // Rotate recirculates the outgoing bit instead of the serial input
    always_comb begin
        fill_r = rot ? q[0]       : sin_r;
        fill_l = rot ? q[WIDTH-1] : sin_l;
    end
`else
    logic unused_rot;
    assign unused_rot = rot;

    // Without rotate support the serial inputs always feed the shifts
    always_comb begin
        fill_r = sin_r;
        fill_l = sin_l;
    end
`endif

    // Next register contents for the selected mode
    always_comb begin
        q_nxt = q;
        case (mode_e)
            MODE_SHR:  q_nxt = {fill_r, q[WIDTH-1:1]};
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], fill_l};
            MODE_LOAD: q_nxt = pin;
            default:   q_nxt = q;
        endcase
    end

    // Register state; reset wins over enable and mode
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= q_nxt;
        end
    end

    assign inc = en && is_shift(mode_e);
    assign clr = en && (mode_e == MODE_LOAD);

    usr_frame_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc),
        .clr        (clr),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    assign pout   = q;
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_usr_shift_reg.sv
// Self-checking bench for usr_shift_reg (WIDTH=4): directed scenarios with
// literal expectations plus randomized traffic, all checked every cycle
// against a behavioural model through an expected-value queue.
module tb_usr_shift_reg;

    localparam int W     = 4;
    localparam int CNT_W = $clog2(W);
    localparam int EXP_W = W + CNT_W + 1;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic             rot;
    logic [W-1:0]     pin;
    logic [W-1:0]     pout;
    logic             sout_r;
    logic             sout_l;
    logic [CNT_W-1:0] shift_cnt;
    logic             frame_done;

    int checks = 0;
    int errors = 0;

    logic [EXP_W-1:0] exp_q[$];

    usr_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .rot        (rot),
        .pin        (pin),
        .pout       (pout),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // Register value as an integer, shifts counted as a plain number of
    // shifts since the frame started; a frame closes after W shifts.
    int m_val  = 0;
    int m_shft = 0;
    int m_done = 0;
    int fill;

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            m_val = 0; m_shft = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (en) begin
                if (mode == 2'd1) begin
                    fill = sin_r;
`ifdef USR_ROTATE_EN
                    if (rot) fill = m_val % 2;
`endif
                    m_val = (m_val / 2) + fill * (1 << (W - 1));
                end else if (mode == 2'd2) begin
                    fill = sin_l;
`ifdef USR_ROTATE_EN
                    if (rot) fill = (m_val >> (W - 1)) % 2;
`endif
                    m_val = (m_val * 2 + fill) % (1 << W);
                end else if (mode == 2'd3) begin
                    m_val  = int'(pin);
                    m_shft = 0;
                end
                if (mode == 2'd1 || mode == 2'd2) begin
                    m_shft = m_shft + 1;
                    if (m_shft == W) begin
                        m_shft = 0;
                        m_done = 1;
                    end
                end
            end
        end
        exp_q.push_back({W'(m_val), CNT_W'(m_shft), 1'(m_done)});
    end

    // ---------------- scoreboard: compare every cycle ----------------
    logic [EXP_W-1:0] exp_v;
    logic [W-1:0]     e_pout;
    logic [CNT_W-1:0] e_cnt;
    logic             e_done;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v  = exp_q.pop_front();
            e_pout = exp_v[EXP_W-1 -: W];
            e_cnt  = exp_v[CNT_W:1];
            e_done = exp_v[0];
            checks++;
            if (pout !== e_pout || sout_r !== e_pout[0] || sout_l !== e_pout[W-1] ||
                shift_cnt !== e_cnt || frame_done !== e_done) begin
                errors++;
                $display("FAIL model t=%0t pout=%b/%b sout_r=%b sout_l=%b cnt=%0d/%0d done=%b/%b (actual/expected)",
                         $time, pout, e_pout, sout_r, sout_l, shift_cnt, e_cnt, frame_done, e_done);
            end
        end
    end

    // ---------------- literal checks and drivers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [1:0] m, input logic sr,
                        input logic sl, input logic r, input logic [W-1:0] p);
        rst = 1'b1; en = e; mode = m; sin_r = sr; sin_l = sl; rot = r; pin = p;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    logic [W-1:0] rot_exp;

    initial begin
        rst = 1'b0; en = 1'b1; mode = 2'b11; sin_r = 1'b0; sin_l = 1'b0;
        rot = 1'b0; pin = 4'b1111;

        // Reset dominates a pending load
        reset_cycles(2);
        check("reset_pout", pout, 4'b0000);
        check("reset_cnt", shift_cnt, 0);
        check("reset_done", frame_done, 0);
        step(1, 2'b11, 0, 0, 0, 4'b1111);
        check("load_1111", pout, 4'b1111);

        // Shift right frame
        reset_cycles(1);
        step(1, 2'b01, 0, 0, 0, 0); check("shr1", pout, 4'b0000);
        step(1, 2'b01, 1, 0, 0, 0); check("shr2", pout, 4'b1000);
        step(1, 2'b01, 1, 0, 0, 0); check("shr3", pout, 4'b1100);
        check("shr3_no_done", frame_done, 0);
        step(1, 2'b01, 0, 0, 0, 0); check("shr4", pout, 4'b0110);
        check("shr4_done", frame_done, 1);
        check("shr4_cnt_wrap", shift_cnt, 0);
        step(1, 2'b00, 0, 0, 0, 0); check("done_one_cycle", frame_done, 0);

        // Direction change mid-frame
        step(1, 2'b11, 0, 0, 0, 4'b1001);
        step(1, 2'b01, 0, 0, 0, 0); check("dir_shr", pout, 4'b0100);
        step(1, 2'b10, 0, 1, 0, 0); check("dir_shl1", pout, 4'b1001);
        step(1, 2'b10, 0, 1, 0, 0); check("dir_shl2", pout, 4'b0011);
        check("dir_cnt3", shift_cnt, 3);
        step(1, 2'b10, 0, 1, 0, 0); check("dir_shl3", pout, 4'b0111);
        check("dir_sout_l", sout_l, 0);
        check("dir_done", frame_done, 1);

        // Enable / hold gating
        step(1, 2'b11, 0, 0, 0, 4'b1010);
        step(0, 2'b01, 1, 0, 0, 0);
        step(1, 2'b00, 1, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0, 0);
        step(0, 2'b01, 1, 0, 0, 0);
        step(1, 2'b00, 1, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0, 0);
        step(0, 2'b11, 0, 0, 0, 4'b1111);
        step(1, 2'b01, 0, 0, 0, 0);
        check("gate_pout", pout, 4'b0001);
        check("gate_cnt", shift_cnt, 3);

        // Load where the final shift of the frame would have been
        step(1, 2'b11, 0, 0, 0, 4'b0101);
        check("ld_final_pout", pout, 4'b0101);
        check("ld_final_cnt", shift_cnt, 0);
        check("ld_final_done", frame_done, 0);

        // Reset mid-frame
        step(1, 2'b01, 1, 0, 0, 0);
        step(1, 2'b01, 1, 0, 0, 0);
        check("mid_cnt2", shift_cnt, 2);
        reset_cycles(1);
        check("mid_rst_pout", pout, 0);
        check("mid_rst_cnt", shift_cnt, 0);

        // Rotate (or plain shift when rotate is compiled out)
        step(1, 2'b11, 0, 0, 0, 4'b0001);
        for (int i = 0; i < W; i++) step(1, 2'b01, 0, 0, 1, 0);
`ifdef USR_ROTATE_EN
        rot_exp = 4'b0001;
`else
        rot_exp = 4'b0000;
`endif
        check("rot_final", pout, rot_exp);
        check("rot_done", frame_done, 1);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                reset_cycles(1);
            end else begin
                step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), W'($urandom_range(0, (1 << W) - 1)));
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
